// File: rtl/clearpass_pkg.sv
// Shared sizing for the keypad password-entry block.
package clearpass_pkg;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned PASS_W  = DIGITS * DIGIT_W;
  localparam int unsigned CNT_W   = $clog2(DIGITS + 1);

endpackage

// File: rtl/clear_pass_if.sv
// Keypad-side bus of clear_pass: digit/strobe inputs and the two password registers.
interface clear_pass_if;

  logic [clearpass_pkg::DIGIT_W-1:0] keyboard_value;
  logic                              key_en;
  logic                              clearPass;
  logic [clearpass_pkg::PASS_W-1:0]  passvalue;
  logic [clearpass_pkg::PASS_W-1:0]  password;

  modport master (
    output keyboard_value, key_en, clearPass,
    input  passvalue, password
  );

  modport slave (
    input  keyboard_value, key_en, clearPass,
    output passvalue, password
  );

endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector: one-cycle pulse when the input goes from 0 to 1.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= 1'b0;
    else      prev_q <= in;
  end

  assign pulse = in & ~prev_q;

endmodule

// File: rtl/clear_pass.sv
// Keypad password entry with backspace; password latched on the 4th digit.
// Define CLEARPASS_CLRALL_EN to make a clear press wipe all entered digits at once.
module clear_pass
  import clearpass_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  clear_pass_if.slave  bus
);

  logic             key_pulse;
  logic             clr_pulse;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [PASS_W-1:0] pwd_q,  pwd_d;

  edge_detect u_key_edge (
    .clk   (clk),
    .rst   (rst),
    .in    (bus.key_en),
    .pulse (key_pulse)
  );

  edge_detect u_clr_edge (
    .clk   (clk),
    .rst   (rst),
    .in    (bus.clearPass),
    .pulse (clr_pulse)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      pass_q <= '0;
      pwd_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pass_q <= pass_d;
      pwd_q  <= pwd_d;
    end
  end

  // Clear outranks a simultaneous key press; a full buffer ignores keys.
  always_comb begin
    cnt_d  = cnt_q;
    pass_d = pass_q;
    pwd_d  = pwd_q;
    if (clr_pulse) begin
      if (cnt_q != '0) begin
`ifdef CLEARPASS_CLRALL_EN
        pass_d = '0;
        cnt_d  = '0;
`else
        pass_d = {DIGIT_W'(0), pass_q[PASS_W-1:DIGIT_W]};
        cnt_d  = cnt_q - CNT_W'(1);
`endif
      end
    end else if (key_pulse && (cnt_q < CNT_W'(DIGITS))) begin
      pass_d = {pass_q[PASS_W-DIGIT_W-1:0], bus.keyboard_value};
      cnt_d  = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(DIGITS - 1)) pwd_d = pass_d;
    end
  end

  assign bus.passvalue = pass_q;
  assign bus.password  = pwd_q;

endmodule

// File: tb/tb_clear_pass.sv
// Randomised and directed check of clear_pass against a digit-queue reference model.
module tb_clear_pass;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  clear_pass_if bus ();

  clear_pass dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  digits[$];
  logic [15:0] m_pwd = 16'h0;
  bit          prev_k = 1'b0;
  bit          prev_c = 1'b0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_pass();
    logic [15:0] pv = 16'h0;
    foreach (digits[i]) pv = {pv[11:0], digits[i]};
    return pv;
  endfunction

  function automatic void model_reset();
    digits.delete();
    m_pwd  = 16'h0;
    prev_k = 1'b0;
    prev_c = 1'b0;
  endfunction

  function automatic void model_apply(input bit k, input bit c, input logic [3:0] v);
    bit kp = k && !prev_k;
    bit cp = c && !prev_c;
    prev_k = k;
    prev_c = c;
    if (cp) begin
      if (digits.size() > 0) begin
`ifdef CLEARPASS_CLRALL_EN
        digits.delete();
`else
        void'(digits.pop_back());
`endif
      end
    end else if (kp && digits.size() < 4) begin
      digits.push_back(v);
      if (digits.size() == 4) m_pwd = m_pass();
    end
  endfunction

  // One clock: drive on the falling edge, check just after the rising edge.
  task automatic step(input bit k, input bit c, input logic [3:0] v);
    @(negedge clk);
    bus.key_en         = k;
    bus.clearPass      = c;
    bus.keyboard_value = v;
    model_apply(k, c, v);
    @(posedge clk);
    #1;
    check_eq("pass_model", bus.passvalue, m_pass());
    check_eq("pwd_model", bus.password, m_pwd);
  endtask

  task automatic press_key(input logic [3:0] v, input int hold);
    repeat (hold) step(1'b1, 1'b0, v);
    step(1'b0, 1'b0, v);
  endtask

  task automatic press_clr();
    step(1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    bus.key_en         = 1'b0;
    bus.clearPass      = 1'b0;
    bus.keyboard_value = 4'h0;

    #12;
    check_eq("reset_pass", bus.passvalue, 16'h0000);
    check_eq("reset_pwd", bus.password, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    // Four digits, each held a few cycles
    press_key(4'h1, 2); check_eq("enter_1", bus.passvalue, 16'h0001);
    press_key(4'h8, 3); check_eq("enter_18", bus.passvalue, 16'h0018);
    check_eq("pwd_before_4th", bus.password, 16'h0000);
    press_key(4'h7, 2); check_eq("enter_187", bus.passvalue, 16'h0187);
    press_key(4'h4, 3); check_eq("enter_1874", bus.passvalue, 16'h1874);
    check_eq("pwd_latched", bus.password, 16'h1874);

    // Full buffer ignores further keys
    press_key(4'h9, 2);
    check_eq("full_pass", bus.passvalue, 16'h1874);
    check_eq("full_pwd", bus.password, 16'h1874);

`ifdef CLEARPASS_CLRALL_EN
    press_clr(); check_eq("clrall", bus.passvalue, 16'h0000);
`else
    press_clr(); check_eq("clr_1", bus.passvalue, 16'h0187);
    press_clr(); check_eq("clr_2", bus.passvalue, 16'h0018);
    press_clr(); check_eq("clr_3", bus.passvalue, 16'h0001);
    press_clr(); check_eq("clr_4", bus.passvalue, 16'h0000);
`endif
    check_eq("pwd_kept", bus.password, 16'h1874);
    press_clr(); check_eq("clr_empty", bus.passvalue, 16'h0000);

    // Simultaneous key and clear: clear wins
    press_key(4'h1, 1);
    press_key(4'h2, 2);
    check_eq("two_digits", bus.passvalue, 16'h0012);
    step(1'b1, 1'b1, 4'h5);
`ifdef CLEARPASS_CLRALL_EN
    check_eq("both_clear_wins", bus.passvalue, 16'h0000);
`else
    check_eq("both_clear_wins", bus.passvalue, 16'h0001);
`endif
    step(1'b0, 1'b0, 4'h5);

    // Asynchronous reset mid-entry
    press_clr();
    press_key(4'h6, 2);
    press_key(4'h7, 2);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst_pass", bus.passvalue, 16'h0000);
    check_eq("async_rst_pwd", bus.password, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    press_key(4'h3, 2);
    check_eq("after_rst", bus.passvalue, 16'h0003);

`ifdef CLEARPASS_CLRALL_EN
    press_clr();
    press_key(4'h1, 1);
    press_key(4'h8, 1);
    press_key(4'h7, 1);
    press_clr();
    check_eq("clrall_187", bus.passvalue, 16'h0000);
    press_key(4'h2, 1);
    check_eq("clrall_cnt0", bus.passvalue, 16'h0002);
`endif

    // Random strobes and digits
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 3) != 0, ($urandom % 5) == 0, 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clear_pass.md
CLEAR_PASS -- requirements
Module: clear_pass

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst as in the rest of the codebase.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 keyboard_value  input  4  digit code from the keypad; all values 0x0-0xF are accepted.
REQ-005 key_en  input  1  key-press strobe; level may stay high for several cycles.
REQ-006 clearPass  input  1  backspace strobe; level may stay high for several cycles.
REQ-007 passvalue  output  16  digits entered so far, right-aligned; newest digit in bits [3:0].
REQ-008 password  output  16  committed password, latched when the 4th digit is entered.

Function
REQ-009 The block SHALL keep a digit count in the range 0..4, reset to 0.
REQ-010 The block SHALL register key_en and clearPass into previous-sample flops that reset to 0; a press is a cycle where the input is 1 and its previous sample is 0.
REQ-011 On a key press with count<4, passvalue SHALL become {passvalue[11:0], keyboard_value} and the count SHALL increment, both at that same clock edge.
REQ-012 On a key press with count==4, the press SHALL be ignored and all state SHALL hold.
REQ-013 When a key press makes the count 4, password SHALL load the new passvalue at the same edge.
REQ-014 On a clear press with count>0, passvalue SHALL become {4'h0, passvalue[15:4]} and the count SHALL decrement.
REQ-015 On a clear press with count==0, all state SHALL hold.
REQ-016 password SHALL NOT change on a clear press; only a 4th-digit entry or reset changes it.
REQ-017 If a key press and a clear press occur in the same cycle, the clear SHALL win and the key press SHALL be discarded.
REQ-018 A held key_en or clearPass SHALL produce exactly one action per rising edge of the input.
REQ-019 Each output SHALL be driven directly from a register, with no combinational path from any input.

Reset
REQ-020 While rst=0, passvalue, password, the count and both previous-sample flops SHALL be 0, asynchronously.
REQ-021 If reset asserts mid-entry, all partial digits SHALL be lost, and operation SHALL resume at the first clock edge after rst returns to 1.

Configuration
REQ-022 When the macro CLEARPASS_CLRALL_EN is defined, a clear press SHALL set passvalue to 0 and the count to 0 in one cycle; password is still unaffected.
REQ-023 When CLEARPASS_CLRALL_EN is undefined, a clear press SHALL remove one digit, as in REQ-014.

Structure
REQ-024 A shared package clearpass_pkg SHALL hold DIGITS=4, DIGIT_W=4, PASS_W=16 and the count width.
REQ-025 The press detection SHALL be a sub-module edge_detect (clk, rst, in, pulse), instantiated once for key_en and once for clearPass.
REQ-026 The top level SHALL contain only the count, passvalue and password registers and their next-state logic.

Verification
REQ-027 Enter keys 1, 8, 7, 4, each held 2-3 cycles -> passvalue steps 0x0001, 0x0018, 0x0187, 0x1874; password = 0x1874 after the 4th key.
REQ-028 After REQ-027, press clearPass four times -> passvalue steps 0x0187, 0x0018, 0x0001, 0x0000; password stays 0x1874; a 5th clear changes nothing.
REQ-029 With 4 digits stored, press key 0x9 -> passvalue and password stay unchanged.
REQ-030 Raise key_en and clearPass together with value 0x5 and count 2 (passvalue 0x0012) -> passvalue = 0x0001, count = 1.
REQ-031 Pull rst low after 2 digits, mid-clock -> outputs go to 0 immediately; a new entry of 3 gives passvalue 0x0003.
REQ-032 With CLEARPASS_CLRALL_EN defined, enter 1, 8, 7, then clear once -> passvalue = 0x0000, count = 0.
